// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg -- shared types and helpers for the shift-add multiplier
// controller.
//
// Contents:
//   state_t    : controller state encoding (IDLE, LOAD, CALC, DONE)
//   DEF_WIDTH  : default operand width, which is also the number of steps
//   cnt_w()    : width of the step counter for a given operand width
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 16;

  // The counter only ever holds 0..width-1, so $clog2(width) bits are enough.
  // The floor of 1 keeps the counter from collapsing to zero bits.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_mult_step_cnt.sv
// seq_mult_step_cnt -- step counter for the shift-add sequencer.
//
// The counter has three controls, in priority order:
//   clr   : force the count to 0 (highest priority)
//   en    : advance by one; after reaching WIDTH-1 it wraps to 0
//   (none): hold the current value
// The wrap is an explicit comparison against WIDTH-1. This keeps the count
// in 0..WIDTH-1 even when WIDTH is not a power of two.
//
// Ports:
//   clk   in   rising-edge clock
//   clr   in   synchronous clear
//   en    in   count enable
//   count out  current step index [CNT_W-1:0]
//   last  out  count == WIDTH-1 (terminal step)
module seq_mult_step_cnt
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(WIDTH - 1);

  assign last = (count == TERM);

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (en)
      count <= last ? '0 : count + CNT_W'(1);
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl -- control FSM for a shift-add sequential multiplier.
//
// Handshake overview:
//   1. A start request is accepted when start_valid && start_ready.
//   2. In the next cycle, load pulses for one cycle.
//   3. The controller then issues WIDTH step strobes. Each strobe is either
//      add_shift or shift, chosen by the datapath's current multiplier LSB.
//   4. done_valid is then held high until done_ready is seen.
//
// Timing from an accept in cycle t:
//   load               : cycle t+1
//   step strobes       : cycles t+2 .. t+WIDTH+1
//   done_valid rises   : cycle t+WIDTH+2
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous active-high reset
//   abort          in   (only with SEQ_MULT_CTRL_ABORT_EN) cancel the
//                       operation while in LOAD or CALC
//   start_valid    in   start request
//   start_ready    out  controller idle
//   multiplier_lsb in   LSB of the datapath multiplier register
//   load           out  one-cycle operand load / accumulator clear
//   add_shift      out  step strobe: add multiplicand, then shift
//   shift          out  step strobe: shift only
//   step_count     out  steps completed in the current operation
//   busy           out  high in LOAD and CALC
//   done_valid     out  product stable in datapath
//   done_ready     in   consumer accepts product
//
// Optional feature macro: SEQ_MULT_CTRL_ABORT_EN. When it is defined, the
// abort port is added. Without it, every accepted operation runs to DONE.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
`ifdef SEQ_MULT_CTRL_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             multiplier_lsb,
  output logic             load,
  output logic             add_shift,
  output logic             shift,
  output logic [CNT_W-1:0] step_count,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready
);

  state_t           state;
  logic             abort_hit;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_last;
  logic [CNT_W-1:0] cnt;

  // An abort counts only while an operation is in flight (LOAD or CALC).
  // In IDLE and DONE it is ignored.
`ifdef SEQ_MULT_CTRL_ABORT_EN
  assign abort_hit = abort && ((state == LOAD) || (state == CALC));
`else
  assign abort_hit = 1'b0;
`endif

  // The counter is cleared in LOAD so that every operation starts at step 0.
  // It is also cleared on reset and on abort, which drops any partial
  // progress. The counter wraps to 0 by itself on the final CALC step.
  assign cnt_clr = reset || (state == LOAD) || abort_hit;
  assign cnt_en  = (state == CALC) && !abort_hit;

  seq_mult_step_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_step_cnt (
    .clk   (clk),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt),
    .last  (cnt_last)
  );

  assign step_count = cnt;

  // The step strobes follow the live multiplier LSB. The datapath shifts
  // that register on every step, so the LSB seen in a cycle already belongs
  // to that cycle's step. A registered copy would be one step late.
  assign add_shift = cnt_en &&  multiplier_lsb;
  assign shift     = cnt_en && !multiplier_lsb;

  // The FSM registers its handshake and status outputs together with the
  // state, so each output always matches the state it describes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      start_ready <= 1'b1;
      load        <= 1'b0;
      busy        <= 1'b0;
      done_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            state       <= LOAD;
            start_ready <= 1'b0;
            load        <= 1'b1;
            busy        <= 1'b1;
          end
        end

        LOAD: begin
          load <= 1'b0;
          if (abort_hit) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            busy        <= 1'b0;
          end else begin
            state <= CALC;
          end
        end

        CALC: begin
          if (abort_hit) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            busy        <= 1'b0;
          end else if (cnt_last) begin
            // The terminal step fires in this cycle. The counter wraps to
            // 0 on the same edge.
            state      <= DONE;
            busy       <= 1'b0;
            done_valid <= 1'b1;
          end
        end

        DONE: begin
          if (done_ready) begin
            state       <= IDLE;
            done_valid  <= 1'b0;
            start_ready <= 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          start_ready <= 1'b1;
          load        <= 1'b0;
          busy        <= 1'b0;
          done_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// tb_seq_mult_ctrl -- directed self-checking bench for seq_mult_ctrl with
// WIDTH=16.
//
// Inputs are driven 1 time unit after each rising edge. Outputs are checked
// once they have settled, before the next rising edge.
module tb_seq_mult_ctrl;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             start_valid;
  logic             start_ready;
  logic             multiplier_lsb;
  logic             load;
  logic             add_shift;
  logic             shift;
  logic [CNT_W-1:0] step_count;
  logic             busy;
  logic             done_valid;
  logic             done_ready;
`ifdef SEQ_MULT_CTRL_ABORT_EN
  logic             abort;
`endif

  int checks = 0;
  int errors = 0;

  seq_mult_ctrl #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .reset          (reset),
`ifdef SEQ_MULT_CTRL_ABORT_EN
    .abort          (abort),
`endif
    .start_valid    (start_valid),
    .start_ready    (start_ready),
    .multiplier_lsb (multiplier_lsb),
    .load           (load),
    .add_shift      (add_shift),
    .shift          (shift),
    .step_count     (step_count),
    .busy           (busy),
    .done_valid     (done_valid),
    .done_ready     (done_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe exclusivity is checked on every falling edge, outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      assert ($onehot0({load, add_shift, shift})) else begin
        errors++;
        $error("FAIL onehot observed=%b expected=onehot0", {load, add_shift, shift});
      end
    end
  end

  // Runs one complete operation starting from IDLE.
  //   mode 0: multiplier LSB 1,0,1,...
  //   mode 1: LSB all 1
  //   mode 2: LSB all 0
  // done_ready is held low for `hold` cycles in DONE before the accept.
  task automatic run_op(input int mode, input int hold);
    logic b;
    chk("op_idle_ready", start_ready, 1);
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    chk("op_load", load, 1);
    chk("op_load_busy", busy, 1);
    chk("op_load_ready", start_ready, 0);
    tick();
    for (int k = 0; k < WIDTH; k++) begin
      b = (mode == 0) ? (k % 2 == 0) : (mode == 1);
      multiplier_lsb = b;
      #1;
      chk("step_add", add_shift, b);
      chk("step_shift", shift, !b);
      chk("step_cnt", step_count, k);
      chk("step_busy", busy, 1);
      chk("step_done", done_valid, 0);
      tick();
    end
    multiplier_lsb = 1'b1;
    #1;
    chk("done_valid", done_valid, 1);
    chk("done_cnt", step_count, 0);
    chk("done_busy", busy, 0);
    chk("done_nostrobe", add_shift | shift, 0);
    chk("done_ready_lo", start_ready, 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", done_valid, 1);
      chk("hold_nostrobe", add_shift | shift, 0);
    end
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("after_done_valid", done_valid, 0);
    chk("after_done_ready", start_ready, 1);
  endtask

  initial begin
    int loads[$];
    int seen_done;
    int t;

    reset = 1'b1;
    start_valid = 1'b0;
    multiplier_lsb = 1'b0;
    done_ready = 1'b0;
`ifdef SEQ_MULT_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_ready", start_ready, 1);
    chk("rst_load", load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_valid, 0);
    chk("rst_cnt", step_count, 0);
    chk("rst_strobe", add_shift | shift, 0);

    // Alternating LSB pattern, with done_ready held low for 5 cycles in DONE.
    run_op(0, 5);

    // Back-to-back operations: start_valid and done_ready both held high.
    start_valid = 1'b1;
    done_ready  = 1'b1;
    for (int c = 0; c < 64; c++) begin
      tick();
      if (load) loads.push_back(c);
      if (busy || done_valid) chk("b2b_ready_lo", start_ready, 0);
    end
    start_valid = 1'b0;
    chk("b2b_nloads", (loads.size() >= 3), 1);
    if (loads.size() >= 3) begin
      chk("b2b_interval1", loads[1] - loads[0], WIDTH + 3);
      chk("b2b_interval2", loads[2] - loads[1], WIDTH + 3);
    end
    t = 0;
    while (!start_ready && t < 40) begin
      tick();
      t++;
    end
    chk("b2b_drain", start_ready, 1);
    done_ready = 1'b0;
    tick();

    // Reset arrives on the 7th CALC cycle.
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    repeat (6) tick();
    chk("mid_cnt", step_count, 6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", start_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt", step_count, 0);
    chk("mid_rst_done", done_valid, 0);
    seen_done = 0;
    repeat (20) begin
      tick();
      if (done_valid) seen_done = 1;
    end
    chk("mid_no_done", seen_done, 0);

    run_op(0, 0);
    run_op(1, 0);
    run_op(2, 1);

`ifdef SEQ_MULT_CTRL_ABORT_EN
    // Abort at CALC step 3.
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    repeat (3) tick();
    chk("ab_cnt3", step_count, 3);
    abort = 1'b1;
    multiplier_lsb = 1'b1;
    #1;
    chk("ab_nostrobe", add_shift | shift, 0);
    tick();
    abort = 1'b0;
    chk("ab_idle", start_ready, 1);
    chk("ab_cnt0", step_count, 0);
    chk("ab_busy", busy, 0);
    seen_done = 0;
    repeat (20) begin
      tick();
      if (done_valid) seen_done = 1;
    end
    chk("ab_no_done", seen_done, 0);

    // An abort seen in DONE has no effect.
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    repeat (WIDTH + 1) tick();
    chk("ab_done_reach", done_valid, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_done_hold", done_valid, 1);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("ab_done_exit", start_ready, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
